systolic_matmul_stream: RTL and testbench
=========================================

# systolic_matmul_stream

Parametrised streaming N×N matrix multiplier for the systolic-array datapath. Accepts one A/B matrix pair per valid/ready handshake, skews the operands into an internal N×N multiply-accumulate grid, and returns C = A·B on a held output port with valid/ready back-pressure. Compared with the earlier fixed 8-bit/32-bit top level, it adds configurable operand and accumulator widths, a signed mode, input and output handshakes, and one-deep result buffering so the next multiplication overlaps result drain.

## Interface
- N, default 4: matrix dimension; N >= 2, elaboration error otherwise.
- DATA_W, default 8: operand element width.
- ACC_W, default 32: accumulator/result element width; ACC_W >= 2*DATA_W, elaboration error otherwise.
- SIGNED, default 0: 1 = two's-complement operands and results; 0 = unsigned.

- i_clk  in  1  clock; everything is on the rising edge.
- i_arst  in  1  reset; synchronous and active-high.
- i_a  in  [N-1:0][N-1:0][DATA_W-1:0]  matrix A, indexed [row][col].
- i_b  in  [N-1:0][N-1:0][DATA_W-1:0]  matrix B, indexed [row][col].
- i_valid  in  1  A/B pair is valid.
- i_ready  out  1  block can accept a pair.
- o_c  out  [N-1:0][N-1:0][ACC_W-1:0]  result C, indexed [row][col].
- o_valid  out  1  o_c holds an unconsumed result.
- o_ready  in  1  consumer takes o_c.
- o_busy  out  1  a multiplication is in flight (state not IDLE).

## Operation
- Control FSM states:
  - IDLE: i_ready=1.
    - On accept (i_valid & i_ready): load the feeders, clear all accumulators and PE pipeline registers, set count=0, go to RUN.
  - RUN: one MAC step per cycle; count increments.
    - After 3N-2 steps, go to CAPTURE.
  - CAPTURE: if the output register is free, or is being emptied this cycle, copy all accumulators to o_c, set o_valid=1, go to IDLE. Otherwise stay in CAPTURE with accumulators frozen.
- Output register is free when o_valid=0 or (o_valid & o_ready).
- o_valid clears on o_ready unless a new capture happens in the same cycle; a capture takes priority and keeps o_valid=1.
- Feeders: one per row of A and one per column of B, each 2N-1 element slots.
  - Row i is loaded with A[i][0..N-1], delayed by i zero slots.
  - Column j is loaded with B[0..N-1][j], delayed by j zero slots.
  - Each feeder shifts one slot per RUN cycle and back-fills with zero.
- PE(i,j):
  - Registers its a-operand to PE(i,j+1) and its b-operand to PE(i+1,j).
  - Accumulates a*b. At MAC step k (0..3N-3) it sees A[i][t]*B[t][j] with t=k-i-j. Out-of-range t gives zero operands.
- Arithmetic:
  - Product is 2*DATA_W bits, sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to ACC_W.
  - Accumulation wraps modulo 2^ACC_W. No saturation, no overflow flag.
- i_a/i_b are sampled only on the accept edge; changes at any other time are ignored.

## Timing
- Reset values: o_c=0, o_valid=0, i_ready=1, o_busy=0, FSM=IDLE, feeders, PEs and count all zero.
- Reset mid-operation aborts the multiplication, discards any held result, and returns to the reset values on the next edge.
- Latency: with the accept on edge E, o_valid is first high after edge E+3N-1 when the output register is free (N=4: 11 cycles).
- o_busy is high from after E until the CAPTURE edge.
- i_ready=0 for edges E+1 through the CAPTURE edge; it is 1 the cycle after CAPTURE.
- Peak throughput: one accept every 3N cycles.
- Back-pressure: CAPTURE waits indefinitely. While waiting, accumulators, feeders and o_c are stable, and o_c stays stable while o_valid=1 & o_ready=0.
- CAPTURE with o_ready=1 in the same cycle: the old result is consumed and the new one loaded on that edge. o_valid stays 1 and the result is not lost.
- i_valid while i_ready=0: ignored, no side effects.

## Test plan
- Identity: N=4, DATA_W=8, ACC_W=32, unsigned. A=I, B[r][c]=4r+c+1 -> o_c equals B, o_valid rises exactly 11 cycles after the accept, and lasts 1 cycle with o_ready=1.
- Unsigned full scale: all A and B elements 255 -> every o_c element is 260100. Same stimulus with ACC_W=16 -> every element is 63492 (wrap).
- Signed: SIGNED=1, A all -128, B all 127 -> every o_c element is 0xFFFF0200 (-65024).
- Back-pressure and overlap: two accepted pairs, o_ready held 0.
  - First result is held stable; second run stalls in CAPTURE with i_ready=0.
  - Raise o_ready for one cycle -> first result consumed, second captured on the same edge, o_valid stays 1.
- Back-to-back: i_valid held 1 with o_ready=1 -> accepts every 12 cycles for N=4, and each result matches a software golden model for random operands.
- Reset mid-run: assert i_arst at count 5 -> the next cycle shows o_valid=0, o_c=0, o_busy=0, i_ready=1. A fresh accept then produces the correct result.

Source files
------------

// File: rtl/systolic_matmul_stream.sv
// -----------------------------------------------------------------------------
// systolic_matmul_stream
//
// Streaming N x N matrix multiplier built around an N x N grid of
// multiply-accumulate cells. A/B operand pairs are accepted through a
// valid/ready handshake and skewed into the grid by per-row and per-column
// feeders. C = A*B is returned on a held output register with valid/ready
// back-pressure. The single output register acts as a one-deep result buffer,
// so the next multiplication runs while the previous result waits to drain.
//
// Parameters
//   N       matrix dimension (>= 2)
//   DATA_W  operand element width
//   ACC_W   accumulator / result element width (>= 2*DATA_W)
//   SIGNED  1 = two's-complement operands and results, 0 = unsigned
//
// Ports
//   i_clk    clock, rising edge
//   i_arst   synchronous active-high reset
//   i_a      matrix A [row][col]; sampled only on the accept edge
//   i_b      matrix B [row][col]; sampled only on the accept edge
//   i_valid  A/B pair valid
//   i_ready  block can accept a pair (FSM idle)
//   o_c      result C [row][col]
//   o_valid  o_c holds an unconsumed result
//   o_ready  consumer takes o_c
//   o_busy   a multiplication is in flight
// -----------------------------------------------------------------------------
module systolic_matmul_stream #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int SIGNED = 0
) (
    input  logic                                 i_clk,
    input  logic                                 i_arst,
    input  logic [N-1:0][N-1:0][DATA_W-1:0]      i_a,
    input  logic [N-1:0][N-1:0][DATA_W-1:0]      i_b,
    input  logic                                 i_valid,
    output logic                                 i_ready,
    output logic [N-1:0][N-1:0][ACC_W-1:0]       o_c,
    output logic                                 o_valid,
    input  logic                                 o_ready,
    output logic                                 o_busy
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    if (N < 2) begin : g_bad_n
        $error("systolic_matmul_stream: N must be >= 2");
    end
    if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
        $error("systolic_matmul_stream: ACC_W must be >= 2*DATA_W");
    end

    localparam int SLOTS = 2 * N - 1;   // feeder depth: N data + up to N-1 skew zeros
    localparam int STEPS = 3 * N - 2;   // MAC steps until the last term reaches PE(N-1,N-1)
    localparam int CNT_W = $clog2(STEPS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_CAPTURE
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               count_q, count_d;

    logic [DATA_W-1:0]              a_feed_q [N][SLOTS];
    logic [DATA_W-1:0]              a_feed_d [N][SLOTS];
    logic [DATA_W-1:0]              b_feed_q [N][SLOTS];
    logic [DATA_W-1:0]              b_feed_d [N][SLOTS];

    logic [DATA_W-1:0]              a_pe_q   [N][N];
    logic [DATA_W-1:0]              a_pe_d   [N][N];
    logic [DATA_W-1:0]              b_pe_q   [N][N];
    logic [DATA_W-1:0]              b_pe_d   [N][N];
    logic [ACC_W-1:0]               acc_q    [N][N];
    logic [ACC_W-1:0]               acc_d    [N][N];

    logic [N-1:0][N-1:0][ACC_W-1:0] o_c_q, o_c_d;
    logic                           o_valid_q, o_valid_d;

    // Operands presented to each PE in the current cycle.
    logic [DATA_W-1:0]              a_in     [N][N];
    logic [DATA_W-1:0]              b_in     [N][N];

    logic                           accept;
    logic                           step_en;
    logic                           capture_fire;

    // Product widened to ACC_W; the 2*DATA_W multiply is done on operands
    // already extended to 2*DATA_W so the sign is carried correctly.
    function automatic logic [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic [2*DATA_W-1:0] ax;
        logic [2*DATA_W-1:0] bx;
        logic [2*DATA_W-1:0] p;
        if (SIGNED != 0) begin
            ax = {{DATA_W{a[DATA_W-1]}}, a};
            bx = {{DATA_W{b[DATA_W-1]}}, b};
        end else begin
            ax = {{DATA_W{1'b0}}, a};
            bx = {{DATA_W{1'b0}}, b};
        end
        p = ax * bx;
        if (SIGNED != 0) begin
            return ACC_W'($signed(p));
        end
        return ACC_W'(p);
    endfunction

    // -------------------------------------------------------------------------
    // Control FSM: next state and strobes
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        count_d      = count_q;
        accept       = 1'b0;
        step_en      = 1'b0;
        capture_fire = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    accept  = 1'b1;
                    count_d = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                step_en = 1'b1;
                if (count_q == LAST_STEP) begin
                    count_d = '0;
                    state_d = S_CAPTURE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                // Output register free, or being emptied on this same edge.
                if (!o_valid_q || o_ready) begin
                    capture_fire = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Feeders: row i of A / column j of B, skewed by i / j leading zeros.
    // Slot 0 drives the edge of the grid; each step shifts toward slot 0.
    // -------------------------------------------------------------------------
    always_comb begin
        a_feed_d = a_feed_q;
        b_feed_d = b_feed_q;
        if (accept) begin
            a_feed_d = '{default: '0};
            b_feed_d = '{default: '0};
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    a_feed_d[i][i+k] = i_a[i][k];
                    b_feed_d[i][i+k] = i_b[k][i];
                end
            end
        end else if (step_en) begin
            for (int i = 0; i < N; i++) begin
                for (int s = 0; s < SLOTS - 1; s++) begin
                    a_feed_d[i][s] = a_feed_q[i][s+1];
                    b_feed_d[i][s] = b_feed_q[i][s+1];
                end
                a_feed_d[i][SLOTS-1] = '0;
                b_feed_d[i][SLOTS-1] = '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // PE grid: a flows left->right, b flows top->bottom, one hop per step.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_in[i][0] = a_feed_q[i][0];
            b_in[0][i] = b_feed_q[i][0];
            for (int k = 1; k < N; k++) begin
                a_in[i][k] = a_pe_q[i][k-1];
                b_in[k][i] = b_pe_q[k-1][i];
            end
        end
    end

    always_comb begin
        a_pe_d = a_pe_q;
        b_pe_d = b_pe_q;
        acc_d  = acc_q;
        if (accept) begin
            a_pe_d = '{default: '0};
            b_pe_d = '{default: '0};
            acc_d  = '{default: '0};
        end else if (step_en) begin
            a_pe_d = a_in;
            b_pe_d = b_in;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    // Wraps modulo 2^ACC_W by construction.
                    acc_d[i][j] = acc_q[i][j] + mul_ext(a_in[i][j], b_in[i][j]);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output register: a capture wins over a same-cycle drain.
    // -------------------------------------------------------------------------
    always_comb begin
        o_c_d     = o_c_q;
        o_valid_d = o_valid_q;
        if (capture_fire) begin
            o_valid_d = 1'b1;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    o_c_d[i][j] = acc_q[i][j];
                end
            end
        end else if (o_ready) begin
            o_valid_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (i_arst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            // NOTE: feeder and PE arrays are reset too, so an aborted run
            // leaves no stale operands or partial sums visible anywhere.
            a_feed_q  <= '{default: '0};
            b_feed_q  <= '{default: '0};
            a_pe_q    <= '{default: '0};
            b_pe_q    <= '{default: '0};
            acc_q     <= '{default: '0};
            o_c_q     <= '0;
            o_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            a_feed_q  <= a_feed_d;
            b_feed_q  <= b_feed_d;
            a_pe_q    <= a_pe_d;
            b_pe_q    <= b_pe_d;
            acc_q     <= acc_d;
            o_c_q     <= o_c_d;
            o_valid_q <= o_valid_d;
        end
    end

    assign i_ready = (state_q == S_IDLE);
    assign o_busy  = (state_q != S_IDLE);
    assign o_c     = o_c_q;
    assign o_valid = o_valid_q;

endmodule

// File: tb/tb_systolic_matmul_stream.sv
// -----------------------------------------------------------------------------
// Testbench for systolic_matmul_stream.
// Three instances share stimulus: the default configuration (unsigned,
// ACC_W=32) is fully scoreboarded; an ACC_W=16 and a SIGNED=1 instance cover
// wrap-around and signed arithmetic on the full-scale vectors.
// -----------------------------------------------------------------------------
module tb_systolic_matmul_stream;

    localparam int N  = 4;
    localparam int DW = 8;

    typedef logic [N-1:0][N-1:0][DW-1:0] opm_t;
    typedef logic [N-1:0][N-1:0][31:0]   resm_t;

    logic                        clk = 1'b0;
    logic                        arst;
    opm_t                        a, b;
    logic                        i_valid, o_ready;
    logic                        i_ready, o_valid, o_busy;
    resm_t                       o_c;
    logic [N-1:0][N-1:0][15:0]   c16;
    logic                        rdy16, v16, busy16;
    resm_t                       cs;
    logic                        rdys, vs, busys;

    always #5 clk = ~clk;

    systolic_matmul_stream #(.N(N), .DATA_W(DW), .ACC_W(32), .SIGNED(0)) dut (
        .i_clk(clk), .i_arst(arst), .i_a(a), .i_b(b), .i_valid(i_valid),
        .i_ready(i_ready), .o_c(o_c), .o_valid(o_valid), .o_ready(o_ready),
        .o_busy(o_busy)
    );

    systolic_matmul_stream #(.N(N), .DATA_W(DW), .ACC_W(16), .SIGNED(0)) dut16 (
        .i_clk(clk), .i_arst(arst), .i_a(a), .i_b(b), .i_valid(i_valid),
        .i_ready(rdy16), .o_c(c16), .o_valid(v16), .o_ready(o_ready),
        .o_busy(busy16)
    );

    systolic_matmul_stream #(.N(N), .DATA_W(DW), .ACC_W(32), .SIGNED(1)) dut_s (
        .i_clk(clk), .i_arst(arst), .i_a(a), .i_b(b), .i_valid(i_valid),
        .i_ready(rdys), .o_c(cs), .o_valid(vs), .o_ready(o_ready),
        .o_busy(busys)
    );

    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    resm_t sb[$];
    int    accept_cyc[$];

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Golden model: plain triple loop, truncated to accw bits.
    function automatic resm_t golden(input opm_t x, input opm_t y, input bit sgn, input int accw);
        resm_t  r;
        longint s, ea, eb;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int t = 0; t < N; t++) begin
                    ea = sgn ? longint'($signed(x[i][t])) : longint'(x[i][t]);
                    eb = sgn ? longint'($signed(y[t][j])) : longint'(y[t][j]);
                    s += ea * eb;
                end
                if (accw < 64) s = s & ((longint'(1) << accw) - 1);
                r[i][j] = s[31:0];
            end
        end
        return r;
    endfunction

    // One clock: scoreboard the handshakes visible before the edge, then
    // advance to 1 time unit past the edge.
    task automatic step();
        resm_t exp_c;
        if (!arst && o_valid === 1'b1 && o_ready === 1'b1) begin
            check("sb_nonempty", (sb.size() != 0), 1'b1);
            if (sb.size() != 0) begin
                exp_c = sb.pop_front();
                check("sb_result", o_c, exp_c);
            end
        end
        if (!arst && i_valid === 1'b1 && i_ready === 1'b1) begin
            sb.push_back(golden(a, b, 1'b0, 32));
            accept_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (arst) sb.delete();
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (o_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("o_valid_seen", o_valid, 1'b1);
    endtask

    task automatic rand_ops();
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                a[r][c] = 8'($urandom);
                b[r][c] = 8'($urandom);
            end
        end
    endtask

    task automatic accept_one();
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int    n;
        resm_t exp_c, p1, p2;
        logic [N-1:0][N-1:0][15:0] exp16;

        // ---------------- reset ----------------
        arst = 1'b1; i_valid = 1'b0; o_ready = 1'b0; a = '0; b = '0;
        step();
        step();
        check("rst_o_valid", o_valid, 1'b0);
        check("rst_o_c",     o_c,     '0);
        check("rst_i_ready", i_ready, 1'b1);
        check("rst_o_busy",  o_busy,  1'b0);
        arst = 1'b0;
        step();

        // ---------------- identity ----------------
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                a[r][c]     = (r == c) ? 8'd1 : 8'd0;
                b[r][c]     = 8'(4 * r + c + 1);
                exp_c[r][c] = 32'(4 * r + c + 1);
            end
        end
        o_ready = 1'b1;
        check("id_i_ready_before", i_ready, 1'b1);
        accept_one();
        a = '1;  // ignored: operands are sampled only on the accept edge
        check("id_busy_after_accept",  o_busy,  1'b1);
        check("id_ready_after_accept", i_ready, 1'b0);
        wait_valid(n);
        check("id_latency", n, 11);
        check("id_result",  o_c, exp_c);
        step();
        check("id_valid_one_cycle", o_valid, 1'b0);

        // ---------------- unsigned full scale / 16-bit wrap ----------------
        a = '1; b = '1;
        accept_one();
        wait_valid(n);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                exp_c[r][c] = 32'd260100;
                exp16[r][c] = 16'd63492;
            end
        end
        check("full_u32",  o_c, exp_c);
        check("full_v16",  v16, 1'b1);
        check("full_u16",  c16, exp16);
        step();

        // ---------------- signed ----------------
        a = {N*N{8'h80}};
        b = {N*N{8'h7F}};
        accept_one();
        wait_valid(n);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                exp_c[r][c] = 32'hFFFF0200;
            end
        end
        check("signed_valid",  vs, 1'b1);
        check("signed_result", cs, exp_c);
        step();

        // ---------------- back-pressure and overlap ----------------
        o_ready = 1'b0;
        rand_ops();
        p1 = golden(a, b, 1'b0, 32);
        accept_one();
        wait_valid(n);
        check("bp_first", o_c, p1);
        rand_ops();
        p2 = golden(a, b, 1'b0, 32);
        check("bp_ready_second", i_ready, 1'b1);
        accept_one();
        for (int k = 0; k < 14; k++) begin
            // Offers while busy must be ignored.
            i_valid = (k > 3 && k < 8);
            a = ~a;
            step();
        end
        i_valid = 1'b0;
        check("bp_hold_c",     o_c,     p1);
        check("bp_hold_valid", o_valid, 1'b1);
        check("bp_stall_rdy",  i_ready, 1'b0);
        check("bp_stall_busy", o_busy,  1'b1);
        o_ready = 1'b1;
        step();
        o_ready = 1'b0;
        check("bp_swap_valid", o_valid, 1'b1);
        check("bp_swap_c",     o_c,     p2);
        check("bp_swap_busy",  o_busy,  1'b0);
        check("bp_swap_rdy",   i_ready, 1'b1);
        o_ready = 1'b1;
        step();
        check("bp_drained", o_valid, 1'b0);

        // ---------------- back-to-back ----------------
        accept_cyc.delete();
        rand_ops();
        i_valid = 1'b1;
        for (int k = 0; k < 80 && accept_cyc.size() < 4; k++) begin
            n = accept_cyc.size();
            step();
            if (accept_cyc.size() != n) rand_ops();
        end
        i_valid = 1'b0;
        check("b2b_accepts", accept_cyc.size(), 4);
        for (int k = 1; k < accept_cyc.size(); k++) begin
            check("b2b_interval", accept_cyc[k] - accept_cyc[k-1], 12);
        end
        wait_valid(n);
        step();

        // ---------------- reset mid-run ----------------
        o_ready = 1'b0;
        rand_ops();
        accept_one();
        wait_valid(n);
        rand_ops();
        accept_one();
        for (int k = 0; k < 5; k++) step();
        arst = 1'b1;
        step();
        check("mid_rst_o_valid", o_valid, 1'b0);
        check("mid_rst_o_c",     o_c,     '0);
        check("mid_rst_o_busy",  o_busy,  1'b0);
        check("mid_rst_i_ready", i_ready, 1'b1);
        arst    = 1'b0;
        o_ready = 1'b1;
        rand_ops();
        exp_c = golden(a, b, 1'b0, 32);
        accept_one();
        wait_valid(n);
        check("post_rst_latency", n, 11);
        check("post_rst_result",  o_c, exp_c);
        step();
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
